hps_gpio_bank: RTL and testbench

- Parametrised general-purpose I/O bank on the HPS lightweight HPS-to-FPGA bridge inside the soc_system fabric.
- Memory-mapped as an Avalon-MM slave with fixed read latency.
- Provides NUM_CH bidirectional channels with per-channel direction, input synchronisation and debounce, programmable rising/falling edge capture, and a maskable level interrupt to the HPS GIC.
- Supersedes single-purpose fixed-width PIOs; one instance is used per board I/O group (LEDs, keys, switches, headers).

---
 rtl/hps_gpio_pkg.sv | 27 ++
 rtl/hps_gpio_bank_debounce.sv | 44 ++++
 rtl/hps_gpio_bank.sv | 95 +++++++++
 tb/tb_hps_gpio_bank.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/hps_gpio_pkg.sv
// hps_gpio_pkg: register offsets and elaboration helpers for the GPIO bank
package hps_gpio_pkg;
  localparam logic [2:0] REG_DATA_IN    = 3'd0;
  localparam logic [2:0] REG_DATA_OUT   = 3'd1;
  localparam logic [2:0] REG_DIR        = 3'd2;
  localparam logic [2:0] REG_IRQ_MASK   = 3'd3;
  localparam logic [2:0] REG_EDGE_CAP   = 3'd4;
  localparam logic [2:0] REG_RISE_EN    = 3'd5;
  localparam logic [2:0] REG_FALL_EN    = 3'd6;
  localparam logic [2:0] REG_OUT_TOGGLE = 3'd7;

  // Counter width for values 0..v-1, never below one bit
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic bit num_ch_ok(input int n);
    return n >= 1 && n <= 32;
  endfunction

  function automatic bit sync_stages_ok(input int n);
    return n >= 2 && n <= 4;
  endfunction
endpackage

// File: rtl/hps_gpio_bank_debounce.sv
// gpio_debounce: per-channel synchroniser plus stability-count debounce
module gpio_debounce
  import hps_gpio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic                   w_sync;
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign dout   = r_stable;
  // Shift the asynchronous pad through the synchroniser chain
  always_ff @(posedge clk or posedge reset)
    if (reset) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], din};
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // No filtering: follow the synchronised input directly
    always_ff @(posedge clk or posedge reset)
      if (reset) r_stable <= 1'b0;
      else       r_stable <= w_sync;
  end else begin : g_filter
    logic [CW-1:0] r_cnt;
    // Accept a change only after it has been seen for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (w_sync == r_stable) begin
        r_cnt    <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt    <= '0;
        r_stable <= w_sync;
      end else begin
        r_cnt    <= r_cnt + 1'b1;
      end
  end
endmodule

// File: rtl/hps_gpio_bank.sv
// hps_gpio_bank: Avalon-MM GPIO bank with direction, debounce, edge capture and irq
module hps_gpio_bank
  import hps_gpio_pkg::*;
#(
  parameter int              NUM_CH          = 8,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter logic [NUM_CH-1:0] OUT_RESET     = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  input  logic [NUM_CH-1:0] gpio_in,
  output logic [NUM_CH-1:0] gpio_out,
  output logic [NUM_CH-1:0] gpio_oe,
  output logic              irq
);
  if (!num_ch_ok(NUM_CH) || !sync_stages_ok(SYNC_STAGES)) begin : g_bad_param
    $error("hps_gpio_bank: NUM_CH must be 1..32 and SYNC_STAGES 2..4");
  end
  // Registers are held 32 bits wide with unimplemented bits forced to zero
  localparam logic [31:0] CH_MASK = {32{1'b1}} >> (32 - NUM_CH);
  logic [31:0]       r_out, r_dir, r_mask, r_cap, r_rise_en, r_fall_en, r_rdata;
  logic              r_irq;
  logic [NUM_CH-1:0] r_stable_d;
  logic [NUM_CH-1:0] w_stable, w_rise, w_fall;
  logic [31:0]       w_wd, w_set, w_rmux;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpio_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (gpio_in[i]),
      .dout (w_stable[i])
    );
  end
  assign w_wd         = avs_writedata & CH_MASK;
  assign w_rise       = w_stable & ~r_stable_d;
  assign w_fall       = ~w_stable & r_stable_d;
  assign w_set        = 32'((w_rise & r_rise_en[NUM_CH-1:0]) | (w_fall & r_fall_en[NUM_CH-1:0]));
  assign gpio_out     = r_out[NUM_CH-1:0];
  assign gpio_oe      = r_dir[NUM_CH-1:0];
  assign irq          = r_irq;
  assign avs_readdata = r_rdata;
  // Read mux over the register map
  always_comb begin
    w_rmux = '0;
    case (avs_address)
      REG_DATA_IN:  w_rmux = 32'(w_stable);
      REG_DATA_OUT: w_rmux = r_out;
      REG_DIR:      w_rmux = r_dir;
      REG_IRQ_MASK: w_rmux = r_mask;
      REG_EDGE_CAP: w_rmux = r_cap;
      REG_RISE_EN:  w_rmux = r_rise_en;
      REG_FALL_EN:  w_rmux = r_fall_en;
      default:      w_rmux = '0;
    endcase
  end
  // Control registers; OUT_TOGGLE flips DATA_OUT in place
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_out     <= 32'(OUT_RESET);
      r_dir     <= '0;
      r_mask    <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (avs_write) begin
      r_out     <= avs_address == REG_DATA_OUT ? w_wd : avs_address == REG_OUT_TOGGLE ? r_out ^ w_wd : r_out;
      r_dir     <= avs_address == REG_DIR      ? w_wd : r_dir;
      r_mask    <= avs_address == REG_IRQ_MASK ? w_wd : r_mask;
      r_rise_en <= avs_address == REG_RISE_EN  ? w_wd : r_rise_en;
      r_fall_en <= avs_address == REG_FALL_EN  ? w_wd : r_fall_en;
    end
  // Edge capture with write-1-to-clear; a new edge beats a simultaneous clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_stable_d <= '0;
      r_cap      <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_stable_d <= w_stable;
      r_cap      <= (r_cap & ~(avs_write && avs_address == REG_EDGE_CAP ? w_wd : 32'd0)) | w_set;
      r_irq      <= |(r_cap & r_mask);
    end
  // Registered read data, one cycle after the read strobe
  always_ff @(posedge clk or posedge reset)
    if (reset) r_rdata <= '0;
    else       r_rdata <= avs_read ? w_rmux : '0;
endmodule

// File: tb/tb_hps_gpio_bank.sv
// tb_hps_gpio_bank: scoreboard bench for the GPIO bank
module tb_hps_gpio_bank;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out, gpio_oe;
  logic        irq;
  logic        rd_pend;
  int          n_run = 0;
  int          n_fail = 0;
  typedef struct {
    string       tag;
    logic [31:0] exp;
  } rd_t;
  rd_t q[$];

  hps_gpio_bank #(
    .NUM_CH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .OUT_RESET(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    rd_t e;
    e.tag = tag; e.exp = exp;
    q.push_back(e);
    avs_address = a; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
  endtask

  always @(posedge clk or posedge reset)
    if (reset) rd_pend <= 1'b0;
    else       rd_pend <= avs_read;

  always @(negedge clk)
    if (rd_pend) begin
      rd_t e;
      if (q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        check(e.tag, avs_readdata, e.exp);
      end
    end

  initial begin
    repeat (2) tick();
    check("rst_out", 32'(gpio_out), 32'h00);
    check("rst_oe", 32'(gpio_oe), 32'h00);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", avs_readdata, 32'h0);
    reset = 1'b0;
    tick();
    for (int a = 0; a < 8; a++) rd(3'(a), 32'h0, $sformatf("rst_reg%0d", a));
    wr(3'd2, 32'hFF);
    check("dir_oe", 32'(gpio_oe), 32'hFF);
    wr(3'd1, 32'h0F);
    check("out_wr", 32'(gpio_out), 32'h0F);
    wr(3'd7, 32'h3C);
    check("out_tog", 32'(gpio_out), 32'h33);
    rd(3'd1, 32'h33, "rd_out");
    rd(3'd7, 32'h0, "rd_tog");
    wr(3'd5, 32'h01);
    wr(3'd3, 32'h01);
    gpio_in[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("irq_lat%0d", i), 32'(irq), 32'(i >= 8));
    end
    rd(3'd0, 32'h01, "din0");
    rd(3'd4, 32'h01, "cap0");
    wr(3'd4, 32'h01);
    check("irq_hold", 32'(irq), 32'h1);
    tick();
    check("irq_clr", 32'(irq), 32'h0);
    wr(3'd5, 32'h02);
    wr(3'd6, 32'h02);
    wr(3'd3, 32'h03);
    gpio_in[1] = 1'b1;
    repeat (3) tick();
    gpio_in[1] = 1'b0;
    repeat (10) tick();
    rd(3'd0, 32'h01, "glitch_din");
    rd(3'd4, 32'h00, "glitch_cap");
    check("glitch_irq", 32'(irq), 32'h0);
    gpio_in[1] = 1'b1;
    repeat (7) tick();
    rd(3'd4, 32'h02, "rise_cap");
    check("rise_irq", 32'(irq), 32'h1);
    wr(3'd4, 32'h02);
    tick();
    check("rise_irq_clr", 32'(irq), 32'h0);
    gpio_in[1] = 1'b0;
    repeat (7) tick();
    rd(3'd4, 32'h02, "fall_cap");
    rd(3'd0, 32'h01, "fall_din");
    wr(3'd4, 32'h02);
    wr(3'd5, 32'h04);
    gpio_in[2] = 1'b1;
    repeat (6) tick();
    wr(3'd4, 32'h04);
    rd(3'd4, 32'h04, "set_wins");
    wr(3'd3, 32'h07);
    tick();
    check("irq_ch2", 32'(irq), 32'h1);
    gpio_in = 8'h04;
    repeat (8) tick();
    rd(3'd0, 32'h04, "pre_rst_din");
    gpio_in = 8'h01;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_out", 32'(gpio_out), 32'h00);
    check("mid_rst_oe", 32'(gpio_oe), 32'h00);
    check("mid_rst_irq", 32'(irq), 32'h0);
    check("mid_rst_rdata", avs_readdata, 32'h0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    rd(3'd0, 32'h00, "rel_din_early");
    rd(3'd0, 32'h01, "rel_din");
    rd(3'd4, 32'h00, "rel_cap");
    rd(3'd1, 32'h00, "rel_out");
    repeat (2) tick();
    check("sb_drain", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
